// File: rtl/sram_arbiter_ctrl.sv
// N-channel arbiter and setup/strobe/hold timing controller for a byte-wide async SRAM; ack 4+WAIT_STATES cycles after an idle-bus request.
// Round-robin by default; defining SRAM_FIXED_PRIO_EN selects fixed priority (lowest index wins). Repeat strobes on a pending channel are dropped.
module sram_arbiter_ctrl #(
  parameter int ADDR_W      = 21,
  parameter int NCH         = 2,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk_chipset,
  input  logic                  reset_n,
  input  logic [NCH-1:0]        ch_req,
  input  logic [NCH-1:0]        ch_we,
  input  logic [NCH*ADDR_W-1:0] ch_addr,
  input  logic [NCH*8-1:0]      ch_wdata,
  output logic [NCH-1:0]        ch_busy,
  output logic [NCH-1:0]        ch_ack,
  output logic [7:0]            ch_rdata,
  output logic [ADDR_W-1:0]     SRAM_ADDR,
  inout  wire  [7:0]            SRAM_DATA,
  output logic                  SRAM_WE_n
);
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [NCH-1:0]    pend_q, pend_d;
  logic [NCH-1:0]    slot_we_q, slot_we_d;
  logic [ADDR_W-1:0] slot_addr_q [NCH];
  logic [ADDR_W-1:0] slot_addr_d [NCH];
  logic [7:0]        slot_wdata_q [NCH];
  logic [7:0]        slot_wdata_d [NCH];
  logic [GW-1:0]     grant_q, grant_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              cur_we_q, cur_we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_n_q, we_n_d;
  logic              oe_q, oe_d;
  logic [NCH-1:0]    ack_q, ack_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [GW-1:0]     sel;
  logic [GW-1:0]     idx;
  logic              found;

`ifdef SRAM_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = GW'(k);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end
`else
  logic [GW-1:0] last_q, last_d;

  // Search begins one past the previous winner so every channel gets a turn.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = GW'((int'(last_q) + k) % NCH);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    last_d = (state_q == S_IDLE && found) ? sel : last_q;
  end

  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n) last_q <= GW'(NCH - 1);
    else          last_q <= last_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    slot_we_d    = slot_we_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    cur_we_d     = cur_we_q;
    wdata_d      = wdata_q;
    addr_d       = addr_q;
    we_n_d       = 1'b1;
    oe_d         = oe_q;
    ack_d        = '0;
    rdata_d      = rdata_q;
    // Output registers are loaded with the value for the state being entered.
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d     = sel;
          pend_d[sel] = 1'b0;
          addr_d      = slot_addr_q[sel];
          cur_we_d    = slot_we_q[sel];
          wdata_d     = slot_wdata_q[sel];
          oe_d        = slot_we_q[sel];
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = 4'(WAIT_STATES);
        we_n_d  = ~cur_we_q;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          if (!cur_we_q) rdata_d = SRAM_DATA;
          ack_d[grant_q] = 1'b1;
          state_d        = S_HOLD;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          we_n_d = ~cur_we_q;
        end
      end
      default: begin
        oe_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    for (int i = 0; i < NCH; i++) begin
      if (ch_req[i] && !pend_q[i]) begin
        pend_d[i]       = 1'b1;
        slot_we_d[i]    = ch_we[i];
        slot_addr_d[i]  = ch_addr[i*ADDR_W +: ADDR_W];
        slot_wdata_d[i] = ch_wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_chipset or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      slot_we_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        slot_addr_q[i]  <= '0;
        slot_wdata_q[i] <= '0;
      end
      grant_q  <= '0;
      cnt_q    <= '0;
      cur_we_q <= 1'b0;
      wdata_q  <= '0;
      addr_q   <= '0;
      we_n_q   <= 1'b1;
      oe_q     <= 1'b0;
      ack_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      slot_we_q    <= slot_we_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      cur_we_q     <= cur_we_d;
      wdata_q      <= wdata_d;
      addr_q       <= addr_d;
      we_n_q       <= we_n_d;
      oe_q         <= oe_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    ch_busy = pend_q;
    if (state_q != S_IDLE) ch_busy[grant_q] = 1'b1;
  end

  assign ch_ack    = ack_q;
  assign ch_rdata  = rdata_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_n = we_n_q;
  assign SRAM_DATA = oe_q ? wdata_q : 8'bz;

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Bench for sram_arbiter_ctrl: a timeline/queue reference model checked every cycle on a default
// instance, plus directed checks on a 4-channel, zero-wait-state, 19-bit instance.
module tb_sram_arbiter_ctrl;
  localparam int AW = 21, N = 2, WS = 1;
  localparam int BAW = 19, BN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [N-1:0] req, we, busy, ack;
  logic [N*AW-1:0] addr;
  logic [N*8-1:0] wdat;
  logic [7:0] rdata;
  logic [AW-1:0] sa;
  logic swe;
  tri1 [7:0] sd;

  logic [BN-1:0] req_b, we_b, busy_b, ack_b;
  logic [BN*BAW-1:0] addr_b;
  logic [BN*8-1:0] wdat_b;
  logic [7:0] rdata_b;
  logic [BAW-1:0] sa_b;
  logic swe_b;
  tri1 [7:0] sd_b;

  sram_arbiter_ctrl #(.ADDR_W(AW), .NCH(N), .WAIT_STATES(WS)) dut (
    .clk_chipset(clk), .reset_n(rst_n), .ch_req(req), .ch_we(we), .ch_addr(addr),
    .ch_wdata(wdat), .ch_busy(busy), .ch_ack(ack), .ch_rdata(rdata),
    .SRAM_ADDR(sa), .SRAM_DATA(sd), .SRAM_WE_n(swe));

  sram_arbiter_ctrl #(.ADDR_W(BAW), .NCH(BN), .WAIT_STATES(0)) dut_b (
    .clk_chipset(clk), .reset_n(rst_n), .ch_req(req_b), .ch_we(we_b), .ch_addr(addr_b),
    .ch_wdata(wdat_b), .ch_busy(busy_b), .ch_ack(ack_b), .ch_rdata(rdata_b),
    .SRAM_ADDR(sa_b), .SRAM_DATA(sd_b), .SRAM_WE_n(swe_b));

  // SRAM device models: write on WE_n rising, read data driven by the bench.
  logic [7:0] sram [logic [AW-1:0]];
  logic [7:0] bmem [logic [BAW-1:0]];
  logic tb_drv = 1'b0, b_rd = 1'b0;
  logic [7:0] tb_dout = 8'h00, b_dout = 8'h00;
  assign sd   = tb_drv ? tb_dout : 8'bz;
  assign sd_b = b_rd ? b_dout : 8'bz;
  always @(posedge swe)   if (rst_n) sram[sa] = sd;
  always @(posedge swe_b) if (rst_n) bmem[sa_b] = sd_b;

  function automatic logic [7:0] srd(logic [AW-1:0] a);
    return sram.exists(a) ? sram[a] : 8'h00;
  endfunction
  function automatic logic [7:0] brd(logic [BAW-1:0] a);
    return bmem.exists(a) ? bmem[a] : 8'h00;
  endfunction

  int n_chk = 0, n_pass = 0, cyc = 0;
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endfunction
  task automatic timeout(string nm);
    n_chk++;
    $display("FAIL %s: timed out waiting for the DUT", nm);
  endtask

  // Reference model: pending set, request slots, and the active access as a timeline
  // (SETUP at m_start, strobe for WS+1 cycles, HOLD at m_start+WS+2).
  logic [N-1:0] m_pend;
  logic s_we [N];
  logic [AW-1:0] s_addr [N];
  logic [7:0] s_wd [N];
  logic m_act, m_we;
  int m_g, m_start, m_last;
  logic [AW-1:0] m_addr;
  logic [7:0] m_wdata, m_rdata;
  logic [7:0] exp_mem [logic [AW-1:0]];

  function automatic logic [7:0] erd(logic [AW-1:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : 8'h00;
  endfunction

  function automatic int choose(logic [N-1:0] p);
`ifdef SRAM_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (p[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (p[(m_last + k) % N]) return (m_last + k) % N;
`endif
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_act = 1'b0; m_we = 1'b0; m_g = 0; m_start = 0; m_last = N - 1;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] pb;
    int off, g;
    pb = m_pend;
    off = cyc - m_start;
    if (m_act) begin
      if (off == WS + 1 && !m_we) m_rdata = erd(m_addr);
      if (off == WS + 2) begin
        if (m_we) exp_mem[m_addr] = m_wdata;
        m_act = 1'b0;
      end
    end else if (pb != '0) begin
      g = choose(pb);
      m_pend[g] = 1'b0; m_act = 1'b1; m_start = cyc + 1; m_g = g; m_last = g;
      m_we = s_we[g]; m_addr = s_addr[g]; m_wdata = s_wd[g];
    end
    for (int i = 0; i < N; i++) begin
      if (req[i] && !pb[i]) begin
        m_pend[i] = 1'b1; s_we[i] = we[i]; s_addr[i] = addr[i*AW +: AW]; s_wd[i] = wdat[i*8 +: 8];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    cyc++;
    #1;
    req = '0; req_b = '0;
    tb_drv = m_act && !m_we && (cyc - m_start) >= 1 && (cyc - m_start) <= WS + 1;
    tb_dout = srd(sa);
  endtask

  task automatic issue(int ch, bit w, logic [AW-1:0] a, logic [7:0] d);
    req[ch] = 1'b1; we[ch] = w; addr[ch*AW +: AW] = a; wdat[ch*8 +: 8] = d;
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while ((busy !== '0 || m_act || m_pend != '0) && n < 200) begin tick(); n++; end
    if (n >= 200) timeout(nm);
  endtask

  task automatic wait_strobe(string nm);
    int n = 0;
    while (swe !== 1'b0 && n < 20) begin tick(); n++; end
    if (swe !== 1'b0) timeout(nm);
  endtask

  logic [N-1:0] ack_log [$];
  int ack_cyc [$];
  int wel_cnt = 0;
  logic chk_on = 1'b0;

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      int off;
      logic [N-1:0] e_ack, e_busy;
      off = cyc - m_start;
      e_ack = '0;
      e_busy = m_pend;
      if (m_act) begin
        e_busy[m_g] = 1'b1;
        if (off == WS + 2) e_ack[m_g] = 1'b1;
      end
      chk("ack", ack, e_ack);
      chk("busy", busy, e_busy);
      chk("we_n", swe, !(m_act && m_we && off >= 1 && off <= WS + 1));
      chk("addr", sa, m_addr);
      chk("rdata", rdata, m_rdata);
      if (m_act && m_we) chk("bus_wr", sd, m_wdata);
      else if (!tb_drv) chk("bus_z", sd, 8'hFF);
      if (ack != '0) begin ack_log.push_back(ack); ack_cyc.push_back(cyc); end
      if (!swe) wel_cnt++;
    end
  end

  logic [BN-1:0] backs [$];
  int backc [$];
  int b_wel = 0;
  task automatic b_run(int n);
    for (int k = 0; k < n; k++) begin
      tick();
      if (ack_b != '0) begin backs.push_back(ack_b); backc.push_back(cyc); end
      if (!swe_b) b_wel++;
    end
  endtask

  initial begin
    int c0;
    rst_n = 1'b1; req = '0; we = '0; addr = '0; wdat = '0;
    req_b = '0; we_b = '0; addr_b = '0; wdat_b = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we_n", swe, 1'b1); chk("rst_addr", sa, 0); chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0); chk("rst_rdata", rdata, 0); chk("rst_bus", sd, 8'hFF);
    chk("rst_b_we_n", swe_b, 1'b1);
    repeat (3) tick();
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Small instance: all four strobe together -> served 0,1,2,3.
    for (int i = 0; i < BN; i++) begin
      req_b[i] = 1'b1; we_b[i] = 1'b1;
      addr_b[i*BAW +: BAW] = BAW'(32'h10 + i); wdat_b[i*8 +: 8] = 8'(8'h10 + i);
    end
    b_run(30);
    chk("b_rr_count", backs.size(), 4);
    for (int i = 0; i < 4 && i < backs.size(); i++) chk("b_rr_order", backs[i], 4'b0001 << i);
    backs.delete(); backc.delete(); b_wel = 0;
    c0 = cyc;
    req_b[2] = 1'b1; we_b[2] = 1'b1; addr_b[2*BAW +: BAW] = 19'h7FFFF; wdat_b[2*8 +: 8] = 8'h5A;
    b_run(12);
    chk("b_wr_acks", backs.size(), 1);
    if (backs.size() > 0) begin
      chk("b_wr_ack_val", backs[0], 4'b0100);
      chk("b_wr_ack_cycle", backc[0] - c0, 4);
    end
    chk("b_wr_we_low", b_wel, 1);
    chk("b_wr_pins", sa_b, 19'h7FFFF);
    chk("b_wr_mem", brd(19'h7FFFF), 8'h5A);
    b_dout = brd(19'h7FFFF); b_rd = 1'b1;
    req_b[1] = 1'b1; we_b[1] = 1'b0; addr_b[1*BAW +: BAW] = 19'h7FFFF;
    b_run(12);
    b_rd = 1'b0;
    chk("b_rd_acks", backs.size(), 2);
    if (backs.size() > 1) chk("b_rd_ack_val", backs[1], 4'b0010);
    chk("b_rd_data", rdata_b, 8'h5A);
    chk("b_rd_we_low", b_wel, 1);

    // Single write: SETUP at +2, WE_n low two cycles, ack at +5.
    ack_log.delete(); ack_cyc.delete(); wel_cnt = 0;
    c0 = cyc;
    issue(0, 1'b1, 21'h1FFFFF, 8'hA5);
    tick();
    wait_idle("t1_idle");
    chk("t1_ack_count", ack_log.size(), 1);
    if (ack_log.size() > 0) begin
      chk("t1_ack_val", ack_log[0], 2'b01);
      chk("t1_ack_cycle", ack_cyc[0] - c0, 5);
    end
    chk("t1_we_low", wel_cnt, 2);
    chk("t1_mem", srd(21'h1FFFFF), 8'hA5);

    issue(1, 1'b0, 21'h1FFFFF, 8'h00);
    tick();
    wait_idle("t2_idle");
    chk("t2_ack_count", ack_log.size(), 2);
    if (ack_log.size() > 1) chk("t2_ack_val", ack_log[1], 2'b10);
    chk("t2_rdata", rdata, 8'hA5);
    chk("t2_we_low", wel_cnt, 2);

    // Both channels strobe together, four rounds -> strict alternation.
    ack_log.delete(); ack_cyc.delete();
    for (int r = 0; r < 4; r++) begin
      issue(0, 1'b0, 21'h200, 8'h00);
      issue(1, 1'b0, 21'h201, 8'h00);
      tick();
      wait_idle("t3_idle");
    end
    chk("t3_count", ack_log.size(), 8);
    for (int i = 0; i < 8 && i < ack_log.size(); i++) chk("t3_order", ack_log[i], (i % 2 == 0) ? 2'b01 : 2'b10);

    // Repeat strobe while pending is dropped; strobe during service is queued.
    ack_log.delete(); ack_cyc.delete();
    issue(0, 1'b0, 21'h100, 8'h00); tick();
    issue(0, 1'b0, 21'h102, 8'h00); tick();
    wait_idle("t4a_idle");
    chk("t4_dup_count", ack_log.size(), 1);
    ack_log.delete(); ack_cyc.delete();
    issue(0, 1'b1, 21'h101, 8'h77); tick();
    wait_strobe("t4_strobe");
    issue(0, 1'b0, 21'h101, 8'h00); tick();
    wait_idle("t4b_idle");
    chk("t4_queued_count", ack_log.size(), 2);
    if (ack_log.size() > 1) chk("t4_gap", ack_cyc[1] - ack_cyc[0], 5);
    chk("t4_rdata", rdata, 8'h77);

    // Reset mid-write strobe: pins release without a clock edge.
    ack_log.delete(); ack_cyc.delete();
    issue(0, 1'b1, 21'h5555, 8'h3C); tick();
    wait_strobe("t5_strobe");
    #2 rst_n = 1'b0;
    #1;
    chk("t5_we_n", swe, 1'b1); chk("t5_bus", sd, 8'hFF);
    chk("t5_busy", busy, 0); chk("t5_ack", ack, 0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    chk("t5_no_ack", ack_log.size(), 0);
    issue(1, 1'b1, 21'h120, 8'h42); tick();
    wait_idle("t5a_idle");
    issue(0, 1'b0, 21'h120, 8'h00); tick();
    wait_idle("t5b_idle");
    chk("t5_after_acks", ack_log.size(), 2);
    chk("t5_after_rdata", rdata, 8'h42);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        we[i] = 1'($urandom_range(0, 1));
        addr[i*AW +: AW] = AW'(32'h100 + $urandom_range(0, 15));
        wdat[i*8 +: 8] = 8'($urandom_range(0, 254));
        req[i] = ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    wait_idle("rand_idle");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
